cdb_broadcaster: RTL

Producer end of the CDB protocol consumed by the reservation stations. Collects completions from NUM_FU functional units into small per-FU buffers and arbitrates them round-robin onto a single registered CDB, one broadcast per cycle. Branch mispredict squashes take priority on the CDB and purge dependent buffered completions. Correct branch resolutions clear the resolved bit from buffered branch masks.

---
 rtl/cdb_broadcaster.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cdb_broadcaster.sv
// Common data bus producer: buffers functional-unit completions per FU and
// arbitrates them round-robin onto one registered CDB, with squash priority.
module cdb_broadcaster #(
  parameter int NUM_FU    = 4,
  parameter int BUF_DEPTH = 2,
  parameter int TAG_W     = 6,
  parameter int BMASK_W   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_FU-1:0]         fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]   fu_tag,
  input  logic [NUM_FU-1:0]         fu_T_used,
  input  logic [NUM_FU*BMASK_W-1:0] fu_bmask,
  output logic [NUM_FU-1:0]         fu_ready,
  input  logic                      br_valid,
  input  logic [BMASK_W-1:0]        br_mask,
  input  logic                      br_mispredict,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic                      cdb_T_used,
  output logic [BMASK_W-1:0]        cdb_branch_mask,
  output logic                      cdb_squash_enable,
  output logic                      busy
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  // Per-FU FIFOs are shift-compacted arrays: slot 0 is always the head.
  logic [TAG_W-1:0]   q_tag     [NUM_FU][BUF_DEPTH];
  logic               q_tused   [NUM_FU][BUF_DEPTH];
  logic [BMASK_W-1:0] q_bmask   [NUM_FU][BUF_DEPTH];
  logic [CNT_W-1:0]   q_cnt     [NUM_FU];
  logic [TAG_W-1:0]   nxt_tag   [NUM_FU][BUF_DEPTH];
  logic               nxt_tused [NUM_FU][BUF_DEPTH];
  logic [BMASK_W-1:0] nxt_bmask [NUM_FU][BUF_DEPTH];
  logic [CNT_W-1:0]   nxt_cnt   [NUM_FU];

  logic [PTR_W-1:0]   rr_ptr, rr_nxt, win;
  logic               have_win, pop_ok, squash, resolve;
  logic               vld_p0, tused_p0, sq_p0;
  logic [TAG_W-1:0]   tag_p0;
  logic [BMASK_W-1:0] mask_p0, clr_mask;

  assign squash   = br_valid & br_mispredict;
  assign resolve  = br_valid & ~br_mispredict;
  assign clr_mask = resolve ? br_mask : '0;
  assign pop_ok   = have_win & ~squash;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = reset && (q_cnt[i] != CNT_W'(BUF_DEPTH));
      busy        = busy | (q_cnt[i] != '0);
    end
  end

  // Scanning downward leaves the nearest non-empty FIFO at/after rr_ptr.
  always_comb begin
    have_win = 1'b0;
    win      = '0;
    for (int off = NUM_FU - 1; off >= 0; off--) begin
      if (q_cnt[(int'(rr_ptr) + off) % NUM_FU] != '0) begin
        have_win = 1'b1;
        win      = PTR_W'((int'(rr_ptr) + off) % NUM_FU);
      end
    end
    rr_nxt = pop_ok ? PTR_W'((int'(win) + 1) % NUM_FU) : rr_ptr;
  end

  // Stage p0: select the next CDB packet (squash outranks completions)
  always_comb begin
    vld_p0   = 1'b0;
    sq_p0    = 1'b0;
    tag_p0   = '0;
    tused_p0 = 1'b0;
    mask_p0  = '0;
    if (squash) begin
      vld_p0  = 1'b1;
      sq_p0   = 1'b1;
      mask_p0 = br_mask;
    end else if (have_win) begin
      vld_p0   = 1'b1;
      tag_p0   = q_tag[win][0];
      tused_p0 = q_tused[win][0];
      mask_p0  = q_bmask[win][0] & ~clr_mask;
    end
  end

  always_comb begin
    int k;
    logic keep;
    k    = 0;
    keep = 1'b0;
    nxt_tag   = q_tag;
    nxt_tused = q_tused;
    nxt_bmask = q_bmask;
    for (int i = 0; i < NUM_FU; i++) begin
      k = 0;
      for (int j = 0; j < BUF_DEPTH; j++) begin
        if (j < int'(q_cnt[i])) begin
          keep = !(squash && ((q_bmask[i][j] & br_mask) != '0)) &&
                 !(pop_ok && (int'(win) == i) && (j == 0));
          if (keep) begin
            nxt_tag[i][k]   = q_tag[i][j];
            nxt_tused[i][k] = q_tused[i][j];
            nxt_bmask[i][k] = q_bmask[i][j] & ~clr_mask;
            k++;
          end
        end
      end
      // A push lands behind whatever survives the pop and the purge.
      if (fu_valid[i] && fu_ready[i] && (k < BUF_DEPTH) &&
          !(squash && ((fu_bmask[i*BMASK_W +: BMASK_W] & br_mask) != '0))) begin
        nxt_tag[i][k]   = fu_tag[i*TAG_W +: TAG_W];
        nxt_tused[i][k] = fu_T_used[i];
        nxt_bmask[i][k] = fu_bmask[i*BMASK_W +: BMASK_W] & ~clr_mask;
        k++;
      end
      nxt_cnt[i] = CNT_W'(k);
    end
  end

  // Stage p1: registered CDB and control state
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FU; i++) q_cnt[i] <= '0;
      rr_ptr            <= '0;
      cdb_valid         <= 1'b0;
      cdb_squash_enable <= 1'b0;
      cdb_tag           <= '0;
      cdb_T_used        <= 1'b0;
      cdb_branch_mask   <= '0;
    end else begin
      q_cnt             <= nxt_cnt;
      rr_ptr            <= rr_nxt;
      cdb_valid         <= vld_p0;
      cdb_squash_enable <= sq_p0;
      cdb_tag           <= tag_p0;
      cdb_T_used        <= tused_p0;
      cdb_branch_mask   <= mask_p0;
    end
  end

  always_ff @(posedge clock) begin
    q_tag   <= nxt_tag;
    q_tused <= nxt_tused;
    q_bmask <= nxt_bmask;
  end

endmodule
